mult_div_unit: RTL and testbench
================================

# mult_div_unit

Iterative 32-bit multiply/divide unit with architectural HI/LO registers. It sits directly downstream of the register file: it consumes the two register read ports as operands and holds results for MFHI/MFLO write-back. The unit performs MULT/MULTU/DIV/DIVU by radix-2 shift-add and restoring division over multiple cycles. It exposes a busy/done handshake so the controller can stall the pipeline.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- clock  input  1  system clock; all state updates on posedge.
- clear_n  input  1  asynchronous active-low reset.
- start  input  1  launch operation; sampled only in IDLE.
- op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- operand_a  input  WIDTH  multiplicand / dividend (register read_data1).
- operand_b  input  WIDTH  multiplier / divisor (register read_data2).
- write_hi  input  1  MTHI strobe.
- write_lo  input  1  MTLO strobe.
- write_data  input  WIDTH  MTHI/MTLO data.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).

## Operation
- States: IDLE, CALC, FIXUP. busy = (state != IDLE).
- IDLE + start: latch operands and op, and set iteration counter to WIDTH-1. Signed ops latch magnitudes plus result-sign flags. Next state is CALC.
- CALC, multiply: each cycle, if the multiplier LSB is 1, add the multiplicand into the upper accumulator. Then shift the {carry, acc} right by one. 2*WIDTH-bit accumulator.
- CALC, divide: each cycle, shift {rem, quo} left by one. Trial-subtract the divisor. If the result is non-negative, keep it and set the quotient LSB.
- After the counter reaches 0, go to FIXUP.
- FIXUP, signed sign correction:
  - MULT: negate the 64-bit product if the operand signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
- FIXUP writes HI/LO, registers done=1, and returns to IDLE.
- Divide by zero: no trap. Result is lo = all ones, hi = operand_a, for both signed and unsigned.
- Signed overflow, 0x80000000 / -1: lo = 0x80000000, hi = 0.
- write_hi/write_lo update HI/LO at the edge, only in IDLE; ignored while busy.
- If start and a write coincide in IDLE, the write takes effect. The later result overwrites it.
- start while busy is ignored and not queued.
- Operands are sampled only at the start edge. Later changes on operand_a/operand_b have no effect.

## Timing
- Reset (clear_n low, asynchronous): state IDLE, hi=0, lo=0, busy=0, done=0.
- Reset mid-operation aborts the operation. HI/LO are cleared and no done is issued.
- Edge E0: start accepted; busy high from E0 until the FIXUP edge.
- Edges E1..E(WIDTH): WIDTH iteration cycles.
- Edge E(WIDTH+1): FIXUP completes.
- After E(WIDTH+1): done=1 for exactly one cycle, hi/lo valid, busy=0.
- Latency: done is visible WIDTH+1 cycles after the start edge (33 for WIDTH=32).
- A new start is accepted in the cycle where done=1, giving back-to-back issue.
- HI/LO stay stable during CALC; intermediates live in internal registers.

## Configuration
- DIVIDE_EN defined: DIVU/DIV implemented as above.
- DIVIDE_EN undefined: divider datapath removed.
  - A start with op[1]=1 enters no CALC. It is acknowledged the next cycle with done=1, busy never high, and HI/LO unchanged.
  - Multiply behaviour is identical in both configurations.

## Structure
- Package multdiv_pkg:
  - op encodings OP_MULTU/OP_MULT/OP_DIVU/OP_DIV.
  - state enum IDLE/CALC/FIXUP.
  - default WIDTH constant.
- One natural sub-module: sign_fixup (combinational). Takes a magnitude result and sign flags, returns the corrected HI/LO. It isolates the negation logic for reuse by the multiply and divide paths.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → done at start+33, hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles.
- MULT −3 × 7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 100 / 0 → lo=0xFFFFFFFF, hi=100. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI 0x12345678 in IDLE → hi updates next edge. MTLO and a second start issued while busy → both ignored; result unchanged.
- Assert clear_n low at cycle 10 of a MULT → hi=lo=0, busy=0, no done. A start afterwards completes normally.
- Back-to-back: second start asserted in the done cycle → accepted, second done exactly 33 cycles later. With DIVIDE_EN undefined, DIVU → done next cycle, HI/LO unchanged.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Purpose : shared op encodings, FSM states and default operand width for mult_div_unit.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package multdiv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } state_t;

endpackage

// File: rtl/mult_div_unit_sign_fixup.sv
// Purpose : turns a magnitude result into a signed HI/LO pair (combinational).
// Latency : 0 cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports: i_wide     - negate {i_hi,i_lo} as one 2*WIDTH value (multiply) when i_neg_lo
//        i_neg_hi   - negate HI on its own (divide remainder)
//        i_neg_lo   - negate LO on its own (divide quotient), or the whole product if i_wide
//        i_hi/i_lo  - magnitude result
//        o_hi/o_lo  - corrected result
import multdiv_pkg::*;

module sign_fixup #(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             i_wide,
    input  logic             i_neg_hi,
    input  logic             i_neg_lo,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_neg;

    assign w_prod     = {i_hi, i_lo};
    assign w_prod_neg = -w_prod;

    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo;
        if (i_wide) begin
            if (i_neg_lo) begin
                o_hi = w_prod_neg[2*WIDTH-1:WIDTH];
                o_lo = w_prod_neg[WIDTH-1:0];
            end
        end else begin
            if (i_neg_hi) o_hi = -i_hi;
            if (i_neg_lo) o_lo = -i_lo;
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Purpose : iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO writes.
// Latency : done pulses WIDTH+1 cycles after the start edge; next start accepted in the done cycle.
// Backpressure: busy high while in flight; start and HI/LO writes while busy are dropped, not queued.
//
// Ports: clock, clear_n (async active-low); start/op/operand_a/operand_b launch an operation;
//        write_hi/write_lo/write_data are MTHI/MTLO; busy/done handshake; hi/lo result registers.
// Build option: define DIVIDE_EN to include the divider; without it a divide start is
//        acknowledged with done on the next cycle and leaves HI/LO untouched.
import multdiv_pkg::*;

module mult_div_unit #(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             write_hi,
    input  logic             write_lo,
    input  logic [WIDTH-1:0] write_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int             CW      = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE = 1;
    localparam logic [CW-1:0]  CNT_TOP = CW'(WIDTH - 1);

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;     // multiply: {product_hi, multiplier}; divide: {rem, quo}
    logic [WIDTH-1:0]   r_opb;     // multiplicand or divisor magnitude
    logic               r_is_div;
    logic               r_neg_hi;
    logic               r_neg_lo;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_done;

    logic               w_accept, w_go;
    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_nxt, w_iter;
    logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

    assign w_accept = (r_state == IDLE) && start;
`ifdef DIVIDE_EN
    assign w_go = w_accept;
`else
    logic w_ack;
    assign w_go  = w_accept && !op[1];
    assign w_ack = w_accept && op[1];
`endif

    // Signed ops iterate on magnitudes; the signs are re-applied in FIXUP.
    assign w_a_neg = op[0] && operand_a[WIDTH-1];
    assign w_b_neg = op[0] && operand_b[WIDTH-1];
    assign w_mag_a = w_a_neg ? -operand_a : operand_a;
    assign w_mag_b = w_b_neg ? -operand_b : operand_b;

    // Shift-add step: conditional add into the upper half, then shift {carry, acc} right.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : '0);
    assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

`ifdef DIVIDE_EN
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_nxt;
    // Restoring step: the partial remainder plus the incoming dividend bit needs WIDTH+1 bits.
    assign w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]} - {1'b0, r_opb};
    assign w_div_nxt   = w_div_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                            : {w_div_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    assign w_iter      = r_is_div ? w_div_nxt : w_mul_nxt;
`else
    assign w_iter      = w_mul_nxt;
`endif

    sign_fixup #(.WIDTH(WIDTH)) u_sign_fixup (
        .i_wide   (!r_is_div),
        .i_neg_hi (r_neg_hi),
        .i_neg_lo (r_neg_lo),
        .i_hi     (r_acc[2*WIDTH-1:WIDTH]),
        .i_lo     (r_acc[WIDTH-1:0]),
        .o_hi     (w_fix_hi),
        .o_lo     (w_fix_lo)
    );

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_go) w_state_nxt = CALC;
            CALC:    if (r_cnt == '0) w_state_nxt = FIXUP;
            FIXUP:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_is_div <= 1'b0;
            r_neg_hi <= 1'b0;
            r_neg_lo <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (write_hi) r_hi <= write_data;
                    if (write_lo) r_lo <= write_data;
                    if (w_go) begin
                        r_cnt    <= CNT_TOP;
                        r_is_div <= op[1];
                        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
                        r_opb    <= op[1] ? w_mag_b : w_mag_a;
                        if (op[1]) begin
                            // Divide by zero keeps the quotient at all ones: no quotient negation.
                            r_neg_lo <= (w_a_neg ^ w_b_neg) && (operand_b != '0);
                            r_neg_hi <= w_a_neg;
                        end else begin
                            r_neg_lo <= w_a_neg ^ w_b_neg;
                            r_neg_hi <= w_a_neg ^ w_b_neg;
                        end
                    end
`ifndef DIVIDE_EN
                    if (w_ack) r_done <= 1'b1;
`endif
                end
                CALC: begin
                    r_acc <= w_iter;
                    r_cnt <= r_cnt - CNT_ONE;
                end
                FIXUP: begin
                    r_hi   <= w_fix_hi;
                    r_lo   <= w_fix_lo;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Purpose : directed self-checking bench for mult_div_unit (both DIVIDE_EN builds).
// Latency : expects done 33 cycles after the start edge.
// Backpressure: exercises dropped start/MTLO while busy and back-to-back issue.
import multdiv_pkg::*;

module tb_mult_div_unit;

    localparam int W = 32;

    logic         clock      = 1'b0;
    logic         clear_n    = 1'b0;
    logic         start      = 1'b0;
    logic [1:0]   op         = 2'b00;
    logic [W-1:0] operand_a  = '0;
    logic [W-1:0] operand_b  = '0;
    logic         write_hi   = 1'b0;
    logic         write_lo   = 1'b0;
    logic [W-1:0] write_data = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clock      (clock),
        .clear_n    (clear_n),
        .start      (start),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .write_hi   (write_hi),
        .write_lo   (write_lo),
        .write_data (write_data),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no end of test, expected $finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Presents an operation for one edge, then scrambles the operand buses.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start     = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        tick();
        start     = 1'b0;
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    // Cycles from now until done is seen (-1 if never), and busy samples on the way.
    task automatic wait_done(output int lat, output int nbusy);
        lat   = -1;
        nbusy = busy ? 1 : 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (done) begin
                lat = k;
                break;
            end
            if (busy) nbusy++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                          input logic [W-1:0] exp_lo);
        int lat, nb;
        issue(o, a, b);
        wait_done(lat, nb);
        check_eq({tag, "_latency"}, lat, 33);
        check_eq({tag, "_hi"}, hi, exp_hi);
        check_eq({tag, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        int lat, nb;

        // Reset state
        tick();
        tick();
        check_eq("rst_hi", hi, 0);
        check_eq("rst_lo", lo, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        clear_n = 1'b1;
        tick();

        // MULTU full-scale with latency and busy length
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(lat, nb);
        check_eq("multu_max_latency", lat, 33);
        check_eq("multu_max_busy_cycles", nb, 33);
        check_eq("multu_max_hi", hi, 32'hFFFF_FFFE);
        check_eq("multu_max_lo", lo, 32'h0000_0001);
        check_eq("multu_max_busy_at_done", busy, 0);
        tick();
        check_eq("multu_max_done_pulse", done, 0);

        // Signed multiply
        run_op("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_m5xm6", OP_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'h1E);
        run_op("mult_maxxmin", OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000);

`ifdef DIVIDE_EN
        run_op("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7dm2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD);
        run_op("divu_100d7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("divu_100d0", OP_DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
        run_op("div_m8d0", OP_DIV, 32'hFFFF_FFF8, 32'd0, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
`else
        // Divider absent: acknowledged next cycle, never busy, HI/LO untouched
        issue(OP_DIVU, 32'd100, 32'd7);
        check_eq("nodiv_ack_done", done, 1);
        check_eq("nodiv_ack_busy", busy, 0);
        check_eq("nodiv_hi_kept", hi, 32'hC000_0000);
        check_eq("nodiv_lo_kept", lo, 32'h8000_0000);
        tick();
        check_eq("nodiv_done_pulse", done, 0);
        check_eq("nodiv_busy_after", busy, 0);
`endif

        // MTHI / MTLO in IDLE
        write_hi   = 1'b1;
        write_data = 32'h1234_5678;
        tick();
        write_hi   = 1'b0;
        check_eq("mthi_hi", hi, 32'h1234_5678);
        write_lo   = 1'b1;
        write_data = 32'hABCD_0000;
        tick();
        write_lo   = 1'b0;
        check_eq("mtlo_lo", lo, 32'hABCD_0000);
        check_eq("mtlo_hi_kept", hi, 32'h1234_5678);

        // MTLO and second start while busy are dropped; HI/LO stable during CALC
        issue(OP_MULTU, 32'd3, 32'd5);
        tick();
        tick();
        check_eq("calc_hi_stable", hi, 32'h1234_5678);
        check_eq("calc_lo_stable", lo, 32'hABCD_0000);
        write_lo   = 1'b1;
        write_data = 32'hDEAD_BEEF;
        start      = 1'b1;
        op         = OP_MULTU;
        operand_a  = 32'd9;
        operand_b  = 32'd9;
        for (int i = 0; i < 5; i++) tick();
        write_lo   = 1'b0;
        start      = 1'b0;
        check_eq("busy_mtlo_ignored", lo, 32'hABCD_0000);
        wait_done(lat, nb);
        check_eq("busy_ign_latency", lat, 26);
        check_eq("busy_ign_hi", hi, 32'h0);
        check_eq("busy_ign_lo", lo, 32'd15);
        tick();
        check_eq("busy_ign_no_requeue", busy, 0);

        // Start coinciding with MTHI: the write lands, then the result overwrites it
        write_hi   = 1'b1;
        write_data = 32'h0000_AAAA;
        issue(OP_MULTU, 32'd2, 32'd3);
        write_hi   = 1'b0;
        check_eq("coincide_write_hi", hi, 32'h0000_AAAA);
        check_eq("coincide_busy", busy, 1);
        wait_done(lat, nb);
        check_eq("coincide_latency", lat, 33);
        check_eq("coincide_hi", hi, 32'h0);
        check_eq("coincide_lo", lo, 32'd6);

        // Reset in the middle of a MULT
        write_hi   = 1'b1;
        write_data = 32'h5555_5555;
        tick();
        write_hi   = 1'b0;
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd5);
        for (int i = 0; i < 9; i++) tick();
        clear_n = 1'b0;
        #1;
        check_eq("midrst_hi", hi, 0);
        check_eq("midrst_lo", lo, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        tick();
        clear_n = 1'b1;
        nb = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) nb++;
        end
        check_eq("midrst_no_done", nb, 0);
        run_op("postrst_6x7", OP_MULTU, 32'd6, 32'd7, 32'h0, 32'd42);

        // Back-to-back: second start raised in the done cycle
        issue(OP_MULTU, 32'h0001_0000, 32'h0001_0000);
        wait_done(lat, nb);
        check_eq("b2b_first_latency", lat, 33);
        check_eq("b2b_first_hi", hi, 32'h1);
        check_eq("b2b_first_lo", lo, 32'h0);
        run_op("b2b_second", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
